matrix_input_loader: RTL and testbench

Write-side front end for the multi-matrix store. Accepts a matrix size, then a stream of elements over a valid/ready handshake. Converts them into a row-major sequence of single-cycle writes on the store's write port, allocating global matrix slots round-robin. It sits between the input path (UART/switch decoder) and the storage block.

---
 rtl/matrix_input_loader.sv | 161 ++++++++++++++++
 tb/tb_matrix_input_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_loader.sv
// Streams a row-major matrix into the multi-matrix store and allocates global slots round-robin.
// Build option: define LOADER_ZERO_FILL_EN so that an aborted load is zero-filled and committed.
module matrix_input_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_SIZE   = 5,
  parameter int unsigned MATRIX_NUM = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIRST_FREE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            cfg_row,
  input  logic [2:0]            cfg_col,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      matrix_idx,
  output logic [2:0]            store_row,
  output logic [2:0]            store_col,
  output logic [ADDR_W-1:0]     wr_addr_in,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      load_idx
);

`ifdef LOADER_ZERO_FILL_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StRecv = 2'd1, StFill = 2'd2, StDone = 2'd3} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StRecv = 2'd1, StDone = 2'd3} state_e;
`endif

  localparam logic [2:0] MaxDim = 3'(MAX_SIZE);

  state_e                  state_q, state_d;
  logic [2:0]              row_q, row_d, col_q, col_d;
  logic [4:0]              total_q, total_d;
  logic [IDX_W-1:0]        slot_q, slot_d, alloc_q, alloc_d, load_idx_q, load_idx_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d, cnt_inc, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
  logic                    dims_ok, last;

  assign dims_ok = (cfg_row != 3'd0) && (cfg_row <= MaxDim) &&
                   (cfg_col != 3'd0) && (cfg_col <= MaxDim);
  assign cnt_inc = cnt_q + 1'b1;
  // True when the write at cnt_q is the final address of the matrix.
  assign last    = (cnt_inc == ADDR_W'(total_q));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    total_d    = total_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    alloc_d    = alloc_q;
    load_idx_d = load_idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (dims_ok) begin
            row_d   = cfg_row;
            col_d   = cfg_col;
            total_d = {2'b00, cfg_row} * {2'b00, cfg_col};
            slot_d  = alloc_q;
            cnt_d   = '0;
            state_d = StRecv;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (abort) begin
`ifdef LOADER_ZERO_FILL_EN
          state_d = StFill;
`else
          state_d = StIdle;
`endif
        end else if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = in_data;
          cnt_d     = cnt_inc;
          if (last) state_d = StDone;
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      StFill: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        cnt_d     = cnt_inc;
        if (last) state_d = StDone;
      end
`endif
      StDone: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        load_idx_d = slot_q;
        alloc_d    = (slot_q == IDX_W'(MATRIX_NUM - 1)) ? '0 : slot_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      total_q    <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      alloc_q    <= IDX_W'(FIRST_FREE);
      load_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      total_q    <= total_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      alloc_q    <= alloc_d;
      load_idx_q <= load_idx_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign in_ready   = (state_q == StRecv) && !abort;
  assign matrix_idx = busy ? slot_q : '0;
  assign store_row  = busy ? row_q : '0;
  assign store_col  = busy ? col_q : '0;
  assign wr_en      = wr_en_q;
  assign wr_addr_in = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign load_idx   = load_idx_q;

endmodule

// File: tb/tb_matrix_input_loader.sv
// Scoreboard bench for matrix_input_loader: expected writes are queued at element acceptance
// and compared as the store write port fires.
module tb_matrix_input_loader;
  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [2:0] cfg_row = '0, cfg_col = '0;
  logic [7:0] in_data = '0;
  logic       in_ready, wr_en, busy, done, err;
  logic [2:0] matrix_idx, store_row, store_col, load_idx;
  logic [5:0] wr_addr_in;
  logic [7:0] wr_data;

  matrix_input_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .matrix_idx(matrix_idx), .store_row(store_row), .store_col(store_col),
    .wr_addr_in(wr_addr_in), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
    .load_idx(load_idx)
  );

  always #5 clk = ~clk;

  // {slot, row, col, addr, data}
  typedef logic [22:0] wr_t;
  wr_t        exp_q[$];
  int         n_tests = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;
  logic [2:0] exp_alloc = 3'd4;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0)
        check_eq("wr_extra", {9'd0, matrix_idx, store_row, store_col, wr_addr_in, wr_data},
                 32'hffff_ffff);
      else
        check_eq("wr", {9'd0, matrix_idx, store_row, store_col, wr_addr_in, wr_data},
                 {9'd0, exp_q.pop_front()});
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {1'b0, wr_en, busy, done, err, in_ready, matrix_idx, store_row, store_col,
                   wr_addr_in, wr_data, load_idx}, 32'd0);
  endtask

  task automatic reset_dut();
    in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_outputs");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    exp_alloc = 3'd4;
  endtask

  task automatic do_start(input logic [2:0] r, input logic [2:0] c);
    cfg_row = r; cfg_col = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feeds n elements base, base+1, ...; gap inserts an idle cycle (with an ignored start).
  task automatic feed(input int n, input logic [7:0] base, input bit gap,
                      input logic [2:0] r, input logic [2:0] c);
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc = 1'b0;
      if (gap && i > 0) begin
        in_valid = 1'b0; start = 1'b1; cfg_row = 3'd0; cfg_col = 3'd0;
        @(negedge clk);
        check_eq("rdy_hold", {31'd0, in_ready}, 32'd1);
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1; in_data = 8'(base + i);
      for (int k = 0; k < 20 && !acc; k++) begin
        @(negedge clk);
        acc = in_ready;
        tick();
      end
      check_eq("accept", {31'd0, acc}, 32'd1);
      if (acc) exp_q.push_back({exp_alloc, r, c, 6'(i), 8'(base + i)});
    end
    in_valid = 1'b0;
  endtask

  task automatic full_load(input logic [2:0] r, input logic [2:0] c, input logic [7:0] base,
                           input bit gap);
    int e0;
    e0 = err_cnt;
    do_start(r, c);
    check_eq("busy_rise", {31'd0, busy}, 32'd1);
    feed(int'(r) * int'(c), base, gap, r, c);
    check_eq("done_state_busy", {31'd0, busy}, 32'd1);
    check_eq("done_early", {31'd0, done}, 32'd0);
    tick();
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_fall", {31'd0, busy}, 32'd0);
    check_eq("load_idx", {29'd0, load_idx}, {29'd0, exp_alloc});
    check_eq("idle_idx", {26'd0, matrix_idx, store_row, store_col}, 32'd0);
    tick();
    check_eq("done_once", {31'd0, done}, 32'd0);
    check_eq("q_empty", exp_q.size(), 32'd0);
    check_eq("no_err_busy", err_cnt, e0);
    exp_alloc = (exp_alloc == 3'd7) ? 3'd0 : exp_alloc + 3'd1;
  endtask

  task automatic bad_start(input logic [2:0] r, input logic [2:0] c);
    do_start(r, c);
    check_eq("err_pulse", {30'd0, err, busy}, 32'd2);
    tick();
    check_eq("err_clear", {30'd0, err, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    #2;
    reset_dut();
    full_load(3'd2, 3'd3, 8'h01, 1'b0);
    reset_dut();
    full_load(3'd2, 3'd3, 8'h01, 1'b1);

    bad_start(3'd0, 3'd3);
    bad_start(3'd6, 3'd2);

    // 3x3 load aborted after 4 elements; abort also beats a valid element
    reset_dut();
    do_start(3'd3, 3'd3);
    feed(4, 8'h10, 1'b0, 3'd3, 3'd3);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hee;
    @(negedge clk);
    check_eq("abort_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    d0 = done_cnt;
`ifdef LOADER_ZERO_FILL_EN
    for (int a = 4; a < 9; a++) exp_q.push_back({exp_alloc, 3'd3, 3'd3, 6'(a), 8'h00});
    for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
    check_eq("abort_done", done_cnt, d0 + 1);
    check_eq("abort_load_idx", {29'd0, load_idx}, 32'd4);
    check_eq("abort_q_empty", exp_q.size(), 32'd0);
    exp_alloc = 3'd5;
`else
    check_eq("abort_idle", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check_eq("abort_no_done", done_cnt, d0);
    check_eq("abort_q_empty", exp_q.size(), 32'd0);
`endif

    for (int i = 0; i < 5; i++) full_load(3'd1, 3'd1, 8'(8'h80 + i), 1'b0);

    // Reset in the middle of a 5x5 load
    reset_dut();
    do_start(3'd5, 3'd5);
    feed(7, 8'h40, 1'b0, 3'd5, 3'd5);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_recv");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    exp_alloc = 3'd4;
    full_load(3'd2, 3'd2, 8'h50, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
